// File: rtl/uart_receiver.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receive path. Re-times the raw RX line, samples each
//               bit mid-period, strobes good bytes and flags bad stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int CLOCKS_PER_BIT = 868,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       serial_connection,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int                 c_CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'((CLOCKS_PER_BIT - 1) / 2);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLOCKS_PER_BIT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_live;
    logic                   r_prev_line;
    logic [1:0]             r_state;
    logic [c_CNT_W-1:0]     r_bit_clock;
    logic [2:0]             r_bit_index;
    logic [7:0]             r_shift;
    logic [7:0]             r_data;
    logic                   r_valid;
    logic                   r_framing_error;

    logic [1:0]             w_state_next;
    logic [c_CNT_W-1:0]     w_bit_clock_next;
    logic [2:0]             w_bit_index_next;
    logic [7:0]             w_shift_next;
    logic [7:0]             w_data_next;
    logic                   w_valid_next;
    logic                   w_framing_error_next;
    logic                   w_rx_s;
    logic                   w_start_edge;

    assign w_rx_s       = r_sync[SYNC_STAGES-1];
    assign w_start_edge = r_prev_line & ~w_rx_s;

    // r_live marks when the synchronizer holds real line samples rather than
    // reset fill; until then prev_line is forced low so a line that is low out
    // of reset cannot fake a falling edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync      <= '1;
            r_live      <= '0;
            r_prev_line <= 1'b1;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], serial_connection};
            r_live      <= {r_live[SYNC_STAGES-2:0], 1'b1};
            r_prev_line <= r_live[SYNC_STAGES-1] ? w_rx_s : 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= c_IDLE;
            r_bit_clock     <= '0;
            r_bit_index     <= 3'd0;
            r_shift         <= 8'h00;
            r_data          <= 8'h00;
            r_valid         <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_bit_clock     <= w_bit_clock_next;
            r_bit_index     <= w_bit_index_next;
            r_shift         <= w_shift_next;
            r_data          <= w_data_next;
            r_valid         <= w_valid_next;
            r_framing_error <= w_framing_error_next;
        end
    end

    always_comb begin
        w_state_next         = r_state;
        w_bit_clock_next     = r_bit_clock;
        w_bit_index_next     = r_bit_index;
        w_shift_next         = r_shift;
        w_data_next          = r_data;
        w_valid_next         = 1'b0;
        w_framing_error_next = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_start_edge) begin
                    w_state_next     = c_START;
                    w_bit_clock_next = '0;
                end
            end
            c_START: begin
                if (r_bit_clock == c_HALF) begin
                    if (!w_rx_s) begin
                        w_state_next     = c_DATA;
                        w_bit_clock_next = '0;
                        w_bit_index_next = 3'd0;
                    end else begin
                        w_state_next = c_IDLE;
                    end
                end else begin
                    w_bit_clock_next = r_bit_clock + 1'b1;
                end
            end
            c_DATA: begin
                if (r_bit_clock == c_LAST) begin
                    w_shift_next[r_bit_index] = w_rx_s;
                    w_bit_clock_next          = '0;
                    w_bit_index_next          = r_bit_index + 3'd1;
                    if (r_bit_index == 3'd7) begin
                        w_state_next = c_STOP;
                    end
                end else begin
                    w_bit_clock_next = r_bit_clock + 1'b1;
                end
            end
            c_STOP: begin
                // Leaving at mid stop bit lets a zero-gap start bit be caught.
                if (r_bit_clock == c_LAST) begin
                    if (w_rx_s) begin
                        w_data_next  = r_shift;
                        w_valid_next = 1'b1;
                    end else begin
                        w_framing_error_next = 1'b1;
                    end
                    w_bit_clock_next = '0;
                    w_state_next     = c_IDLE;
                end else begin
                    w_bit_clock_next = r_bit_clock + 1'b1;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    assign data          = r_data;
    assign valid         = r_valid;
    assign framing_error = r_framing_error;
    assign busy          = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Directed self-checking bench for uart_receiver (16 clk/bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int      c_CPB    = 16;
    localparam realtime c_CLK_NS = 10.0;
    localparam realtime c_BIT_NS = 160.0;

    logic       clock;
    logic       reset_n;
    logic       serial_connection;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       busy;

    int errors = 0;
    int checks = 0;

    int         cycle_num    = 0;
    int         vcount       = 0;
    int         fcount       = 0;
    int         busy_cycles  = 0;
    int         overlap      = 0;
    int         double_pulse = 0;
    logic       prev_pulse   = 1'b0;
    logic [7:0] vdata [64];
    int         vcycle[64];

    uart_receiver #(
        .CLOCKS_PER_BIT(c_CPB),
        .SYNC_STAGES   (2)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .serial_connection(serial_connection),
        .data             (data),
        .valid            (valid),
        .framing_error    (framing_error),
        .busy             (busy)
    );

    initial clock = 1'b0;
    always #(c_CLK_NS / 2.0) clock = ~clock;

    // Pulse log, sampled on the falling edge away from register updates.
    always @(negedge clock) begin
        cycle_num++;
        if (valid) begin
            if (vcount < 64) begin
                vdata[vcount]  = data;
                vcycle[vcount] = cycle_num;
            end
            vcount++;
        end
        if (framing_error) fcount++;
        if (busy) busy_cycles++;
        if (valid && framing_error) overlap++;
        if ((valid || framing_error) && prev_pulse) double_pulse++;
        prev_pulse = valid || framing_error;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input realtime bt);
        serial_connection = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            serial_connection = b[i];
            #(bt);
        end
        serial_connection = stop;
        #(bt);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    int         v0;
    int         f0;
    int         b0;
    int         gap;
    logic [7:0] partial;

    initial begin
        reset_n           = 1'b0;
        serial_connection = 1'b1;
        wait_cycles(5);
        check("reset_data", 32'(data), 32'h00);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_ferr", 32'(framing_error), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        wait_cycles(10);

        // Single good frame
        v0 = vcount; f0 = fcount;
        send_frame(8'h55, 1'b1, c_BIT_NS);
        wait_cycles(4);
        check("t1_valid_count", 32'(vcount - v0), 32'd1);
        check("t1_data", 32'(data), 32'h55);
        check("t1_ferr_count", 32'(fcount - f0), 32'd0);
        check("t1_busy_after", 32'(busy), 32'h0);

        // Two frames, zero idle gap
        v0 = vcount; f0 = fcount;
        send_frame(8'hA3, 1'b1, c_BIT_NS);
        send_frame(8'h00, 1'b1, c_BIT_NS);
        wait_cycles(4);
        check("t2_valid_count", 32'(vcount - v0), 32'd2);
        check("t2_first_data", 32'(vdata[v0]), 32'hA3);
        check("t2_second_data", 32'(vdata[v0+1]), 32'h00);
        gap = vcycle[v0+1] - vcycle[v0];
        check("t2_pulse_gap_in_158_162", 32'(gap >= 158 && gap <= 162), 32'd1);
        check("t2_ferr_count", 32'(fcount - f0), 32'd0);

        // Three-cycle glitch aborts in START
        v0 = vcount; f0 = fcount; b0 = busy_cycles;
        serial_connection = 1'b0;
        wait_cycles(3);
        serial_connection = 1'b1;
        wait_cycles(12);
        check("t3_busy_seen", 32'(busy_cycles > b0), 32'd1);
        check("t3_busy_low", 32'(busy), 32'h0);
        check("t3_valid_count", 32'(vcount - v0), 32'd0);
        check("t3_ferr_count", 32'(fcount - f0), 32'd0);
        wait_cycles(10);

        // Bad stop bit followed by a 40-bit break
        v0 = vcount; f0 = fcount;
        send_frame(8'hFF, 1'b0, c_BIT_NS);
        wait_cycles(2);
        b0 = busy_cycles;
        wait_cycles(40 * c_CPB);
        check("t4_ferr_count", 32'(fcount - f0), 32'd1);
        check("t4_valid_count", 32'(vcount - v0), 32'd0);
        check("t4_data_kept", 32'(data), 32'h00);
        check("t4_no_start_in_break", 32'(busy_cycles - b0), 32'd0);
        check("t4_busy_low", 32'(busy), 32'h0);
        serial_connection = 1'b1;
        wait_cycles(20);

        // Reset in the middle of a frame
        send_frame(8'h5A, 1'b1, c_BIT_NS);
        wait_cycles(4);
        check("t5_pre_data", 32'(data), 32'h5A);
        partial = 8'hA5;
        serial_connection = 1'b0;
        #(c_BIT_NS);
        for (int i = 0; i < 4; i++) begin
            serial_connection = partial[i];
            #(c_BIT_NS);
        end
        #(c_BIT_NS / 4.0);
        check("t5_busy_mid_frame", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #2;
        check("t5_rst_data", 32'(data), 32'h00);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_valid", 32'(valid), 32'h0);
        check("t5_rst_ferr", 32'(framing_error), 32'h0);
        serial_connection = 1'b1;
        wait_cycles(4);
        reset_n = 1'b1;
        wait_cycles(10);
        v0 = vcount; f0 = fcount;
        send_frame(8'h3C, 1'b1, c_BIT_NS);
        wait_cycles(4);
        check("t5_valid_count", 32'(vcount - v0), 32'd1);
        check("t5_data", 32'(data), 32'h3C);
        check("t5_ferr_count", 32'(fcount - f0), 32'd0);
        wait_cycles(10);

        // Baud mismatch, +4% then -4% bit period
        v0 = vcount; f0 = fcount;
        send_frame(8'hC9, 1'b1, c_BIT_NS * 1.04);
        wait_cycles(4);
        check("t6_slow_valid_count", 32'(vcount - v0), 32'd1);
        check("t6_slow_data", 32'(data), 32'hC9);
        check("t6_slow_ferr_count", 32'(fcount - f0), 32'd0);
        wait_cycles(10);
        v0 = vcount; f0 = fcount;
        send_frame(8'hC9, 1'b1, c_BIT_NS * 0.96);
        wait_cycles(4);
        check("t6_fast_valid_count", 32'(vcount - v0), 32'd1);
        check("t6_fast_data", 32'(data), 32'hC9);
        check("t6_fast_ferr_count", 32'(fcount - f0), 32'd0);

        check("pulse_overlap", 32'(overlap), 32'd0);
        check("pulse_back_to_back", 32'(double_pulse), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
